// File: rtl/fm_step4.sv
// Final stage of the float multiply pipeline: normalize, round to nearest-even,
// saturate/flush, and pack {sign, exp, frac}. Two registered stages with valid/ready.
module fm_step4 #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 10
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2*(MAN_W+1)-1:0]           in_mul,
  input  logic [$clog2(2*(MAN_W+1))-1:0]   in_count,
  input  logic [EXP_W-1:0]                 in_ex,
  input  logic                             in_sign,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [EXP_W+MAN_W:0]             out_word,
  output logic                             out_ovf,
  output logic                             out_unf
);

  localparam int unsigned ProdW = 2 * (MAN_W + 1);
  localparam int unsigned CntW  = $clog2(ProdW);
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned WordW = EXP_W + MAN_W + 1;

  // ---------------- Stage A: normalize ----------------
  // Only bits below the leading one are kept; the leading one is implicit.
  logic [ProdW-3:0] norm;
  logic             dropped;
  logic [EW-1:0]    e_in;

  always_comb begin
    norm    = '0;
    dropped = 1'b0;
    if (in_count >= CntW'(ProdW - 1)) begin
      norm    = (ProdW-2)'(in_mul >> 1);
      dropped = in_mul[0];
    end else begin
      norm = (ProdW-2)'(in_mul << (CntW'(ProdW - 2) - in_count));
    end
    e_in = EW'(in_ex) + EW'(in_count) - EW'(ProdW - 2);
  end

  logic             va_q, va_d;
  logic             a_zero_q, a_zero_d;
  logic             a_sign_q, a_sign_d;
  logic [MAN_W-1:0] a_frac_q, a_frac_d;
  logic             a_g_q, a_g_d;
  logic             a_s_q, a_s_d;
  logic [EW-1:0]    a_e_q, a_e_d;

  logic b_load, a_load;

  always_comb begin
    b_load   = !out_valid || out_ready;
    a_load   = !va_q || b_load;
    in_ready = a_load;
  end

  always_comb begin
    va_d     = va_q;
    a_zero_d = a_zero_q;
    a_sign_d = a_sign_q;
    a_frac_d = a_frac_q;
    a_g_d    = a_g_q;
    a_s_d    = a_s_q;
    a_e_d    = a_e_q;
    if (a_load) begin
      va_d = in_valid;
      if (in_valid) begin
        a_zero_d = (in_mul == '0);
        a_sign_d = in_sign;
        a_frac_d = norm[ProdW-3 -: MAN_W];
        a_g_d    = norm[ProdW-3-MAN_W];
        a_s_d    = (|norm[ProdW-4-MAN_W:0]) | dropped;
        a_e_d    = e_in;
      end
    end
  end

  // ---------------- Stage B: round and pack ----------------
  logic             rnd, carry;
  logic [MAN_W-1:0] frac_r;
  logic [EW-1:0]    e_r;
  logic             e_nonpos, e_sat;
  logic [WordW-1:0] word_b;
  logic             ovf_b, unf_b;

  always_comb begin
    rnd             = a_g_q & (a_s_q | a_frac_q[0]);
    // Carry out of the fraction means {1,frac}+1 reached 2.0: frac wraps to 0.
    {carry, frac_r} = {1'b0, a_frac_q} + (MAN_W+1)'(rnd);
    e_r             = a_e_q + EW'(carry);
    e_nonpos        = e_r[EW-1] || (e_r == '0);
    e_sat           = !e_r[EW-1] && (e_r >= EW'((1 << EXP_W) - 1));
    word_b          = '0;
    word_b[WordW-1] = a_sign_q;
    ovf_b           = 1'b0;
    unf_b           = 1'b0;
    if (a_zero_q) begin
      word_b[WordW-2:0] = '0;
    end else if (e_sat) begin
      word_b[WordW-2:MAN_W] = '1;
      ovf_b                 = 1'b1;
    end else if (e_nonpos) begin
      unf_b = 1'b1;
    end else begin
      word_b[WordW-2:0] = {e_r[EXP_W-1:0], frac_r};
    end
  end

  logic             vb_q, vb_d;
  logic [WordW-1:0] word_q, word_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  always_comb begin
    vb_d   = vb_q;
    word_d = word_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (b_load) begin
      vb_d = va_q;
      if (va_q) begin
        word_d = word_b;
        ovf_d  = ovf_b;
        unf_d  = unf_b;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      va_q     <= 1'b0;
      a_zero_q <= 1'b0;
      a_sign_q <= 1'b0;
      a_frac_q <= '0;
      a_g_q    <= 1'b0;
      a_s_q    <= 1'b0;
      a_e_q    <= '0;
      vb_q     <= 1'b0;
      word_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      va_q     <= va_d;
      a_zero_q <= a_zero_d;
      a_sign_q <= a_sign_d;
      a_frac_q <= a_frac_d;
      a_g_q    <= a_g_d;
      a_s_q    <= a_s_d;
      a_e_q    <= a_e_d;
      vb_q     <= vb_d;
      word_q   <= word_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    out_valid = vb_q;
    out_word  = word_q;
    out_ovf   = ovf_q;
    out_unf   = unf_q;
  end

endmodule

// File: tb/tb_fm_step4.sv
// Scoreboard bench for fm_step4: driver pushes expected words, monitor pops on output.
module tb_fm_step4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] in_mul = '0;
  logic [4:0]  in_count = 5'd21;
  logic [7:0]  in_ex = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] out_word;
  logic        out_ovf;
  logic        out_unf;

  fm_step4 dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mul    (in_mul),
    .in_count  (in_count),
    .in_ex     (in_ex),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [18:0] w;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   ready_mode = 0;
  bit   saw_block = 0;

  function automatic logic [4:0] lead(input logic [21:0] mul);
    for (int i = 21; i >= 0; i--) if (mul[i]) return 5'(i);
    return 5'd21;
  endfunction

  // Reference: exact quotient/remainder rounding on the real value mul * 2^(ex-127-20).
  function automatic exp_t model(input logic [21:0] mul, input logic [7:0] ex, input logic sg);
    exp_t   r;
    int     p, e, shift;
    longint m, qv, rem, half;
    r = '0;
    r.w[18] = sg;
    if (mul == 0) return r;
    p     = int'(lead(mul));
    e     = int'(ex) + p - 20;
    m     = longint'(mul) << 11;
    shift = p + 1;
    qv    = m >> shift;
    rem   = m - (qv << shift);
    half  = longint'(1) << (shift - 1);
    if (rem > half || (rem == half && qv[0])) qv++;
    if (qv == 2048) begin
      qv = 1024;
      e++;
    end
    if (e >= 255) begin
      r.w[17:10] = 8'hFF;
      r.ovf      = 1'b1;
    end else if (e <= 0) begin
      r.unf = 1'b1;
    end else begin
      r.w[17:10] = 8'(e);
      r.w[9:0]   = 10'(qv);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic offer(input logic [21:0] mul, input logic [7:0] ex, input logic sg,
                       input bit use_dir, input exp_t dir);
    int   n;
    exp_t e;
    n        = 0;
    e        = use_dir ? dir : model(mul, ex, sg);
    in_mul   = mul;
    in_count = lead(mul);
    in_ex    = ex;
    in_sign  = sg;
    in_valid = 1'b1;
    forever begin
      #2;
      if (in_ready) begin
        q.push_back(e);
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still pending, required 0", q.size());
    end
  endtask

  task automatic lat_check(input logic [21:0] mul, input logic [7:0] ex, input logic sg,
                           input exp_t dir);
    drain();
    out_ready = 1'b1;
    offer(mul, ex, sg, 1'b1, dir);
    #4;
    chk("latency_early", 32'(out_valid), 32'd0);
    @(negedge CLK);
    #4;
    chk("latency_on_time", 32'(out_valid), 32'd1);
    @(negedge CLK);
  endtask

  function automatic logic [21:0] rand_mul();
    int          kind, w;
    logic [21:0] r;
    kind = $urandom_range(0, 9);
    r    = 22'($urandom);
    if (kind == 0) return '0;
    if (kind < 8) begin
      if ($urandom_range(0, 1) == 1) return 22'h200000 | (r & 22'h1FFFFF);
      return 22'h100000 | (r & 22'h0FFFFF);
    end
    w = $urandom_range(1, 21);
    return (r & ((22'd1 << w) - 22'd1)) | (22'd1 << (w - 1));
  endfunction

  // Expected in_ready from pipeline occupancy: blocked only when two words are held.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (started && !RESET) begin
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        if (!in_ready) saw_block = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (ready_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every presented word must equal the oldest expected one, stalled or not.
  initial begin
    forever begin
      @(negedge CLK);
      #3;
      if (started && out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h/%b/%b with no word pending",
                   out_word, out_ovf, out_unf);
        end else begin
          if ({out_word, out_ovf, out_unf} !== q[0]) begin
            errors++;
            $display("FAIL out_word: got %h ovf=%b unf=%b expected %h ovf=%b unf=%b",
                     out_word, out_ovf, out_unf, q[0].w, q[0].ovf, q[0].unf);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] m;
    repeat (3) @(negedge CLK);
    RESET   = 1'b0;
    started = 1;
    #4;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_word", 32'(out_word), 32'd0);
    chk("reset_out_ovf", 32'(out_ovf), 32'd0);
    chk("reset_out_unf", 32'(out_unf), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);

    // Basic values with latency check
    lat_check(22'h100000, 8'd127, 1'b0, {19'h1FC00, 1'b0, 1'b0});
    lat_check(22'h240000, 8'd127, 1'b0, {19'h20080, 1'b0, 1'b0});

    // Rounding and range, back to back
    offer(22'h100200, 8'd127, 1'b0, 1'b1, {19'h1FC00, 1'b0, 1'b0});
    offer(22'h100600, 8'd127, 1'b0, 1'b1, {19'h1FC02, 1'b0, 1'b0});
    offer(22'h100201, 8'd127, 1'b0, 1'b1, {19'h1FC01, 1'b0, 1'b0});
    offer(22'h1FFE00, 8'd127, 1'b0, 1'b1, {19'h20000, 1'b0, 1'b0});
    offer(22'h240000, 8'd254, 1'b0, 1'b1, {19'h3FC00, 1'b1, 1'b0});
    offer(22'h100000, 8'd0,   1'b0, 1'b1, {19'h00000, 1'b0, 1'b1});
    offer(22'h000000, 8'd127, 1'b1, 1'b1, {19'h40000, 1'b0, 1'b0});
    drain();

    // Backpressure: 5 words with a 4-cycle stall after the first
    out_ready = 1'b1;
    saw_block = 0;
    offer(22'h180000, 8'd100, 1'b0, 1'b0, '0);
    fork
      begin
        out_ready = 1'b0;
        repeat (4) @(negedge CLK);
        out_ready = 1'b1;
      end
    join_none
    offer(22'h1A0400, 8'd101, 1'b1, 1'b0, '0);
    offer(22'h2C0000, 8'd102, 1'b0, 1'b0, '0);
    offer(22'h1C0300, 8'd103, 1'b1, 1'b0, '0);
    offer(22'h3F0001, 8'd104, 1'b0, 1'b0, '0);
    drain();
    chk("in_ready_dropped", 32'(saw_block), 32'd1);

    // Reset with both stages full and output stalled
    out_ready = 1'b0;
    offer(22'h110000, 8'd90, 1'b0, 1'b0, '0);
    offer(22'h120000, 8'd91, 1'b1, 1'b0, '0);
    RESET = 1'b1;
    @(negedge CLK);
    q.delete();
    RESET = 1'b0;
    #4;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_word", 32'(out_word), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    lat_check(22'h100000, 8'd127, 1'b1, {19'h5FC00, 1'b0, 1'b0});

    // Randomized streaming
    ready_mode = 1;
    repeat (400) begin
      m = rand_mul();
      offer(m, 8'($urandom_range(0, 255)), 1'($urandom), 1'b0, '0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
    ready_mode = 0;
    out_ready  = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
